// File: rtl/dmem_pkg.sv
// Shared definitions for the load/store stage: FSM state encoding and
// the default access timeout.
package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    // Default number of REQ cycles allowed before a bus error
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter for the memory handshake. Counts while enabled,
// returns to zero on clear, and flags the last permitted cycle.
module wait_timer
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [TW-1:0] count,
    output logic          expire
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins over enable
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = (count_q == LAST);

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store stage between the single-cycle datapath and a variable-latency
// word memory. Issues one req/ack transaction per aligned access and stalls
// the core until it completes, times out, or is rejected as misaligned.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int Size    = 32,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = 5
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [Size-1:0] Addr,
    input  logic [Size-1:0] WriteData,
    output logic [Size-1:0] ReadData,
    output logic            Stall,
    output logic            MisalignErr,
    output logic            BusErr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [Size-1:0] mem_addr,
    output logic [Size-1:0] mem_wdata,
    input  logic [Size-1:0] mem_rdata,
    input  logic            mem_ack
);

    logic [1:0]      state_q,     state_d;
    logic            mem_we_q,    mem_we_d;
    logic [Size-1:0] mem_addr_q,  mem_addr_d;
    logic [Size-1:0] mem_wdata_q, mem_wdata_d;
    logic [Size-1:0] rdata_q,     rdata_d;

    logic            access;
    logic            aligned;
    logic            start;
    logic            misalign;
    logic            in_req;
    logic            got_ack;
    logic            tmr_expire;
    logic [TW-1:0]   tmr_count;

    // Decode of the current access request; only meaningful in IDLE, the
    // inputs of an accepted instruction are never looked at again.
    always_comb begin
        access   = MemRead | MemWrite;
        aligned  = (Addr[1:0] == 2'b00);
        start    = (state_q == IDLE) && access && aligned;
        misalign = (state_q == IDLE) && access && !aligned;
        in_req   = (state_q == REQ);
        got_ack  = in_req && mem_ack;
    end

    // Timer runs only while waiting for ack and sits at zero otherwise
    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_wait_timer (
        .clk    (CLK),
        .rst_n  (Reset),
        .clr    (got_ack || !in_req),
        .en     (in_req),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // Next-state and transaction register update
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A simultaneous read+write request is executed as a write
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {Addr[Size-1:2], 2'b00};
                    mem_wdata_d = WriteData;
                    state_d     = REQ;
                end else if (misalign) begin
                    rdata_d = '0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (tmr_expire) begin
                    rdata_d = '0;
                    state_d = ERR;
                end
            end
            // The core commits during DONE, so the still-asserted request of
            // the finished instruction is deliberately ignored here.
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Outputs; request and status decode from the state flop so an async
    // reset drops them immediately. Stall is raised combinationally in the
    // accepting IDLE cycle so the core never advances past the access.
    always_comb begin
        mem_req     = in_req;
        mem_we      = mem_we_q;
        mem_addr    = mem_addr_q;
        mem_wdata   = mem_wdata_q;
        BusErr      = (state_q == ERR);
        Stall       = Reset && (start || in_req);
        MisalignErr = Reset && misalign;
        ReadData    = misalign ? '0 : rdata_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: aligned load/store, misalignment,
// timeout, async reset mid-transaction and read+write collision.
module tb_data_mem_ctrl;

    logic        CLK;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic        BusErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_tests;
    int n_fail;
    int req_cycles;
    int err_seen;

    data_mem_ctrl #(
        .Size    (32),
        .TIMEOUT (16),
        .TW      (5)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point)
    task automatic drive_pt();
        @(posedge CLK);
        #1;
    endtask

    // Advance to the next falling edge (sample point)
    task automatic sample_pt();
        @(negedge CLK);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        Reset     = 1'b0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Addr      = 32'h10;
        WriteData = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;

        // ---- reset state (aligned request present, must not stall) ----
        #2;
        chk("rst_stall",    {31'd0, Stall}, 32'd0);
        chk("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_buserr",   {31'd0, BusErr}, 32'd0);
        chk("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        MemRead = 1'b0;
        sample_pt();
        Reset = 1'b1;

        // ---- aligned load, ack on 2nd REQ cycle ----
        drive_pt(); MemRead = 1'b1; Addr = 32'h0000_0010;
        sample_pt();
        chk("ld_idle_stall", {31'd0, Stall}, 32'd1);
        chk("ld_idle_req",   {31'd0, mem_req}, 32'd0);
        drive_pt();
        sample_pt();
        chk("ld_req1_req",   {31'd0, mem_req}, 32'd1);
        chk("ld_req1_stall", {31'd0, Stall}, 32'd1);
        chk("ld_mem_addr",   mem_addr, 32'h10);
        chk("ld_mem_we",     {31'd0, mem_we}, 32'd0);
        drive_pt(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        sample_pt();
        chk("ld_req2_stall", {31'd0, Stall}, 32'd1);
        drive_pt(); mem_ack = 1'b0; mem_rdata = 32'h0;
        sample_pt();
        chk("ld_done_stall", {31'd0, Stall}, 32'd0);
        chk("ld_done_req",   {31'd0, mem_req}, 32'd0);
        chk("ld_done_rdata", ReadData, 32'hDEAD_BEEF);
        drive_pt(); MemRead = 1'b0;
        sample_pt();
        chk("ld_after_req",  {31'd0, mem_req}, 32'd0);

        // ---- aligned store, ack on 1st REQ cycle ----
        drive_pt(); MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h1234_5678;
        sample_pt();
        chk("st_idle_stall", {31'd0, Stall}, 32'd1);
        drive_pt(); mem_ack = 1'b1;
        sample_pt();
        chk("st_req_req",    {31'd0, mem_req}, 32'd1);
        chk("st_mem_we",     {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr",   mem_addr, 32'h20);
        chk("st_mem_wdata",  mem_wdata, 32'h1234_5678);
        chk("st_req_stall",  {31'd0, Stall}, 32'd1);
        drive_pt(); mem_ack = 1'b0;
        sample_pt();
        chk("st_done_req",   {31'd0, mem_req}, 32'd0);
        chk("st_done_stall", {31'd0, Stall}, 32'd0);
        chk("st_keep_rdata", ReadData, 32'hDEAD_BEEF);
        drive_pt(); MemWrite = 1'b0;
        sample_pt();
        chk("st_no_retrig",  {31'd0, mem_req}, 32'd0);

        // ---- misaligned load ----
        drive_pt(); MemRead = 1'b1; Addr = 32'h0000_0013;
        sample_pt();
        chk("mis_pulse",     {31'd0, MisalignErr}, 32'd1);
        chk("mis_stall",     {31'd0, Stall}, 32'd0);
        chk("mis_rdata",     ReadData, 32'd0);
        drive_pt(); MemRead = 1'b0;
        sample_pt();
        chk("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);
        chk("mis_no_req",    {31'd0, mem_req}, 32'd0);
        chk("mis_rdata_hold", ReadData, 32'd0);

        // ---- timeout: no ack ----
        drive_pt(); MemRead = 1'b1; Addr = 32'h30;
        sample_pt();
        req_cycles = 0;
        err_seen   = 0;
        for (int i = 0; i < 40; i++) begin
            drive_pt();
            sample_pt();
            if (mem_req) req_cycles++;
            if (BusErr) begin
                err_seen = 1;
                break;
            end
        end
        chk("to_err_seen",   err_seen, 1);
        chk("to_req_cycles", req_cycles, 16);
        chk("to_err_rdata",  ReadData, 32'd0);
        chk("to_err_stall",  {31'd0, Stall}, 32'd0);
        drive_pt(); MemRead = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        sample_pt();
        chk("to_err_pulse",  {31'd0, BusErr}, 32'd0);
        chk("to_late_req",   {31'd0, mem_req}, 32'd0);
        drive_pt(); mem_ack = 1'b0;
        sample_pt();
        chk("to_late_rdata", ReadData, 32'd0);
        chk("to_idle_stall", {31'd0, Stall}, 32'd0);

        // ---- async reset mid-REQ ----
        drive_pt(); MemRead = 1'b1; Addr = 32'h50;
        sample_pt();
        drive_pt();
        sample_pt();
        chk("rr_req_up",     {31'd0, mem_req}, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("rr_req_drop",   {31'd0, mem_req}, 32'd0);
        chk("rr_stall",      {31'd0, Stall}, 32'd0);
        chk("rr_addr",       mem_addr, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        MemRead = 1'b0;
        sample_pt();
        Reset = 1'b1;
        drive_pt();
        sample_pt();
        chk("rr_ack_ign_req", {31'd0, mem_req}, 32'd0);
        chk("rr_ack_ign_rd",  ReadData, 32'd0);
        drive_pt(); mem_ack = 1'b0; MemRead = 1'b1; Addr = 32'h60;
        sample_pt();
        chk("rr_ld_stall",   {31'd0, Stall}, 32'd1);
        drive_pt(); mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        sample_pt();
        chk("rr_ld_addr",    mem_addr, 32'h60);
        drive_pt(); mem_ack = 1'b0;
        sample_pt();
        chk("rr_ld_rdata",   ReadData, 32'hCAFE_F00D);
        chk("rr_ld_stall0",  {31'd0, Stall}, 32'd0);
        drive_pt(); MemRead = 1'b0;
        sample_pt();

        // ---- MemRead and MemWrite together: one write ----
        drive_pt(); MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'h40; WriteData = 32'hA5A5_A5A5;
        sample_pt();
        chk("rw_stall",      {31'd0, Stall}, 32'd1);
        drive_pt(); mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        sample_pt();
        chk("rw_mem_we",     {31'd0, mem_we}, 32'd1);
        chk("rw_mem_addr",   mem_addr, 32'h40);
        chk("rw_mem_wdata",  mem_wdata, 32'hA5A5_A5A5);
        drive_pt(); mem_ack = 1'b0;
        sample_pt();
        chk("rw_no_read",    ReadData, 32'hCAFE_F00D);
        chk("rw_done_req",   {31'd0, mem_req}, 32'd0);
        drive_pt(); MemRead = 1'b0; MemWrite = 1'b0;
        sample_pt();
        chk("rw_idle_req",   {31'd0, mem_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store stage directly downstream of the single-cycle datapath.
- Consumes ALUOut as the address, WriteData as store data, plus the decoder's MemRead/MemWrite.
- Returns ReadData to the datapath's write-back mux.
- Bridges to a variable-latency word memory using a req/ack handshake and raises Stall so the core freezes PC and register writes until the access completes.

Parameters:
- Size, 32, data/address width (matches datapath).
- TIMEOUT, 16, max cycles in REQ without mem_ack before bus error (≥2).
- TW, 5, timeout counter width; must hold TIMEOUT.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (low = reset).
- MemRead  input  1  load request from decoder.
- MemWrite  input  1  store request from decoder.
- Addr  input  Size  byte address (datapath ALUOut).
- WriteData  input  Size  store data (datapath WriteData).
- ReadData  output  Size  load data to datapath.
- Stall  output  1  high = core must hold PC and suppress RegWrite this cycle.
- MisalignErr  output  1  one-cycle pulse: Addr[1:0] != 0 on access.
- BusErr  output  1  one-cycle pulse: access timed out.
- mem_req  output  1  request to memory, held until ack.
- mem_we  output  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  output  Size  word address ({Addr[Size-1:2],2'b00}), registered.
- mem_wdata  output  Size  registered store data.
- mem_rdata  input  Size  read data, valid with mem_ack.
- mem_ack  input  1  memory completion, single-cycle pulse.

Behaviour:
- Reset (Reset=0, async): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, BusErr=0, timer=0. Stall and MisalignErr are 0 while in reset.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - access = MemRead|MemWrite.
  - If access and Addr[1:0]==0: Stall=1 combinationally in the same cycle. Latch addr/wdata/we; next=REQ.
  - If access and Addr[1:0]!=0: MisalignErr=1 and Stall=0 this cycle. No memory request; ReadData=0; stay IDLE.
  - No access: Stall=0.
- MemRead and MemWrite both high: treated as a write (mem_we=1).
- REQ:
  - mem_req=1, Stall=1; timer increments each cycle.
  - mem_ack=1: capture mem_rdata into ReadData (writes leave ReadData unchanged); clear timer; next=DONE.
  - timer reaches TIMEOUT-1 without ack: next=ERR.
  - mem_ack is sampled only in REQ. Ack in any other state is ignored.
- DONE: mem_req=0, Stall=0 (core commits instruction at this edge). next=IDLE unconditionally; the still-asserted MemRead/MemWrite of the same instruction must not retrigger.
- ERR: mem_req=0, Stall=0, BusErr=1, ReadData=0; next=IDLE.
- Latency:
  - Ack in first REQ cycle → load takes 3 cycles (IDLE, REQ, DONE).
  - Minimum stall is 2 cycles.
- Reset mid-transaction: mem_req drops immediately (async). An in-flight ack after reset is ignored.
- mem_addr, mem_wdata and mem_we must not change while mem_req=1.
- Inputs Addr, WriteData and MemRead/MemWrite are held stable by the core while Stall=1; the block does not re-sample them after IDLE.

Decomposition:
- Shared package dmem_pkg: state encoding localparams (IDLE=2'd0, REQ=2'd1, DONE=2'd2, ERR=2'd3) and the default TIMEOUT.
- One sub-module, wait_timer: TW-bit counter with clear/enable/expire flag and async active-low reset.

Test Plan:
- Aligned load, Addr=0x0000_0010, mem_ack on 2nd REQ cycle with mem_rdata=0xDEAD_BEEF → Stall high 3 cycles; ReadData=0xDEAD_BEEF in DONE; mem_addr=0x10, mem_we=0.
- Aligned store, Addr=0x20, WriteData=0x1234_5678, ack on 1st REQ cycle → mem_we=1, mem_wdata=0x1234_5678; Stall 2 cycles; no second request during DONE.
- Misaligned load, Addr=0x0000_0013 → MisalignErr pulses 1 cycle, Stall=0, mem_req never asserts, ReadData=0.
- No ack, TIMEOUT=16 → mem_req high exactly 16 cycles, then BusErr 1-cycle pulse, ReadData=0, state IDLE; a late mem_ack is ignored.
- Reset=0 asserted mid-REQ, then released → mem_req drops asynchronously; all outputs at reset values; next aligned load completes normally.
- MemRead=MemWrite=1, Addr=0x40 → single write transaction (mem_we=1), no read issued.
